d_word_serializer: RTL

- Transmit-side counterpart of the team's D-latch storage elements.
- Captures a parallel WIDTH-bit word on a load enable and shifts it out one bit per clock.
- Drives complementary serial outputs Q/Qnot, with ready/busy/done status.
- Sits between a parallel register bank and a single-wire serial link or downstream flip-flop chain.

---
 rtl/d_word_serializer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/d_word_serializer.sv
// Parallel-to-serial word transmitter with complementary serial outputs and ready/busy/done status.
// Optional even-parity trailer bit enabled by defining D_SERIAL_PARITY_EN.
module d_word_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic             E,
    output logic             Q,
    output logic             Qnot,
    output logic             ready,
    output logic             busy,
    output logic             done
);

`ifdef D_SERIAL_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(NBITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             q_d;
`ifdef D_SERIAL_PARITY_EN
    logic             parity;
    logic             parity_d;
`endif

    // Bit that goes on the wire first for a word in the shift register
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign shifted = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

    // Next-state and next-output logic; cnt counts bits already presented on Q
    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        cnt_d    = cnt;
        q_d      = 1'b0;
`ifdef D_SERIAL_PARITY_EN
        parity_d = parity;
`endif
        case (state)
            IDLE: begin
                if (E) begin
                    state_d  = SHIFT;
                    shreg_d  = D;
                    cnt_d    = CNT_W'(1);
                    q_d      = lead_bit(D);
`ifdef D_SERIAL_PARITY_EN
                    parity_d = ^D;
`endif
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(NBITS)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
`ifdef D_SERIAL_PARITY_EN
                    if (cnt == CNT_W'(WIDTH)) begin
                        q_d = parity;
                    end else begin
                        shreg_d = shifted;
                        q_d     = lead_bit(shifted);
                    end
`else
                    shreg_d = shifted;
                    q_d     = lead_bit(shifted);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; Q and Qnot come from the same next value so they never skew
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            Q      <= 1'b0;
            Qnot   <= 1'b1;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef D_SERIAL_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            shreg  <= shreg_d;
            cnt    <= cnt_d;
            Q      <= q_d;
            Qnot   <= ~q_d;
            ready  <= (state_d == IDLE);
            busy   <= (state_d != IDLE);
            done   <= (state_d == DONE);
`ifdef D_SERIAL_PARITY_EN
            parity <= parity_d;
`endif
        end
    end

endmodule
